// File: rtl/btn_strobe_gen.sv
// Push-button conditioner: two-flop synchronizer, debounce counter, and a
// press/hold FSM that emits single-cycle strobes with optional auto-repeat.
module btn_strobe_gen #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse,
    output logic o_held
);
    localparam int DB = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int RD = CLK_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int RR = CLK_HZ / 1000 * REPEAT_RATE_MS;
    // A period of 1 would put two strobes back to back; stretch it to 2.
    localparam int RD_EFF = (RD < 2) ? 2 : RD;
    localparam int RR_EFF = (RR < 2) ? 2 : RR;
    localparam int TMAX   = (RD_EFF > RR_EFF) ? RD_EFF : RR_EFF;
    localparam int DW     = $clog2(DB + 1);
    localparam int TW     = $clog2(TMAX + 1);

    generate
        if (DB < 1 || RD < 1 || RR < 1) begin : g_bad_param
            $error("btn_strobe_gen: derived cycle counts must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LATCH, DELAY, REPEAT} state_t;

    logic [1:0]    sync_pipe;
    logic          sync;
    logic [DW-1:0] dbc;
    logic          db_done;
    logic          lvl_nxt;
    logic          lvl_rise;
    state_t        state;
    logic [TW-1:0] tmr;

    assign sync = sync_pipe[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[0], i_btn};
    end

    // Next debounced level is visible combinationally so the press strobe and
    // the release gating line up with the o_level edge itself.
    assign db_done  = (sync != o_level) && (dbc == DW'(DB - 1));
    assign lvl_nxt  = db_done ? sync : o_level;
    assign lvl_rise = db_done && sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dbc     <= '0;
            o_level <= 1'b0;
        end else begin
            o_level <= lvl_nxt;
            if (sync == o_level || db_done) dbc <= '0;
            else                            dbc <= dbc + DW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            tmr     <= '0;
            o_pulse <= 1'b0;
            o_held  <= 1'b0;
        end else begin
            o_pulse <= 1'b0;
            // Once released, only a fresh press matters, even if the state
            // has not yet caught up to IDLE.
            if (state == IDLE || !o_level) begin
                o_held <= 1'b0;
                tmr    <= '0;
                if (lvl_rise) begin
                    o_pulse <= 1'b1;
                    state   <= REPEAT_EN ? DELAY : LATCH;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    LATCH: ;
                    DELAY: begin
                        if (tmr == TW'(RD_EFF - 1)) begin
                            tmr     <= '0;
                            state   <= REPEAT;
                            o_pulse <= lvl_nxt;
                            o_held  <= lvl_nxt;
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                    REPEAT: begin
                        o_held <= lvl_nxt;
                        if (tmr == TW'(RR_EFF - 1)) begin
                            tmr     <= '0;
                            o_pulse <= lvl_nxt;
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_btn_strobe_gen.sv
// Directed bench: 1 cycle per ms, DB=4, RD=10, RR=3; one DUT with repeat, one without.
module tb_btn_strobe_gen;
    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic lvl, pls, hld, lvl_n, pls_n, hld_n;
    logic [63:0] pm, lm, hm, pmn, hmn;
    int idx;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btn_strobe_gen #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
                     .REPEAT_RATE_MS(3), .REPEAT_EN(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_level(lvl), .o_pulse(pls), .o_held(hld));

    btn_strobe_gen #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
                     .REPEAT_RATE_MS(3), .REPEAT_EN(1'b0)) dut_nr (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_level(lvl_n), .o_pulse(pls_n), .o_held(hld_n));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        idx = 0; pm = '0; lm = '0; hm = '0; pmn = '0; hmn = '0;
    endtask

    // Hold btn at b for n edges; sample index k is taken just after edge k.
    task automatic run(input int n, input logic b);
        btn = b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            idx++;
            if (idx < 64) begin
                pm[idx] = pls; lm[idx] = lvl; hm[idx] = hld;
                pmn[idx] = pls_n; hmn[idx] = hld_n;
            end
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bits(input int a, input int n, input int step);
        logic [63:0] m = '0;
        for (int i = 0; i < n; i++) m[a + i * step] = 1'b1;
        return m;
    endfunction

    logic [63:0] exp_m;

    initial begin
        rst = 1'b1; btn = 1'b0;
        // reset held while the button toggles
        for (int i = 0; i < 6; i++) begin
            btn = (i % 2 == 0);
            @(posedge clk); #1;
            chk("reset_outputs", {58'd0, lvl, pls, hld, lvl_n, pls_n, hld_n}, 64'd0);
        end
        btn = 1'b0; rst = 1'b0;
        clr(); run(10, 1'b0);
        chk("post_reset_pulse", pm | pmn, 64'd0);
        chk("post_reset_level", lm, 64'd0);

        // clean 8-cycle press
        clr(); run(8, 1'b1); run(14, 1'b0);
        chk("clean_pulse", pm, 64'd1 << 6);
        chk("clean_level", lm, rng(6, 13));
        chk("clean_held", hm, 64'd0);
        chk("clean_pulse_norep", pmn, 64'd1 << 6);

        // bounce 1,0,1,1,0 then high
        clr(); run(1, 1'b1); run(1, 1'b0); run(2, 1'b1); run(1, 1'b0);
        run(21, 1'b1); run(16, 1'b0);
        exp_m = (64'd1 << 11) | bits(21, 4, 3);
        chk("bounce_pulse", pm, exp_m);
        chk("bounce_pulse_norep", pmn, 64'd1 << 11);
        chk("bounce_level", lm, rng(11, 31));

        // 3-cycle glitches while idle
        clr(); run(3, 1'b1); run(10, 1'b0);
        run(1, 1'b1); run(1, 1'b0); run(3, 1'b1); run(8, 1'b0);
        chk("glitch_level", lm, 64'd0);
        chk("glitch_pulse", pm | pmn, 64'd0);

        // hold: release timed so a repeat falls due on the release edge
        clr(); run(31, 1'b1); run(12, 1'b0);
        exp_m = (64'd1 << 6) | bits(16, 7, 3);
        chk("hold_pulse", pm, exp_m);
        chk("hold_level", lm, rng(6, 36));
        chk("hold_held", hm, rng(16, 36));
        chk("hold_pulse_norep", pmn, 64'd1 << 6);
        chk("hold_held_norep", hmn, 64'd0);

        // reset in the middle of REPEAT
        clr(); run(20, 1'b1);
        chk("pre_rst_pulse", pm, (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19));
        chk("pre_rst_held", {63'd0, hld}, 64'd1);
        rst = 1'b1; #1;
        chk("mid_rst_async", {61'd0, lvl, pls, hld}, 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_hold", {58'd0, lvl, pls, hld, lvl_n, pls_n, hld_n}, 64'd0);
        rst = 1'b0;
        clr(); run(20, 1'b1);
        chk("after_rst_pulse", pm, (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19));
        chk("after_rst_held", hm, rng(16, 20));
        chk("after_rst_level", lm, rng(6, 20));
        chk("after_rst_pulse_norep", pmn, 64'd1 << 6);
        clr(); run(15, 1'b0);
        chk("final_release_level", {63'd0, lvl}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
